// File: rtl/machine_mode_types_1_11_pkg.sv
// rtl/machine_mode_types_1_11_pkg.sv - states, cause codes and priority tables for M-mode trap sequencing
package machine_mode_types_1_11_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_COMMIT   = 3'd2;
    localparam logic [2:0] ST_REDIRECT = 3'd3;
    localparam logic [2:0] ST_RET      = 3'd4;

    localparam logic [3:0] EXC_INSN_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_INSN_FAULT     = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_U        = 4'd8;
    localparam logic [3:0] EXC_ECALL_S        = 4'd9;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;
    localparam logic [3:0] EXC_INSN_PAGE      = 4'd12;
    localparam logic [3:0] EXC_LOAD_PAGE      = 4'd13;
    localparam logic [3:0] EXC_STORE_PAGE     = 4'd15;

    localparam logic [3:0] IRQ_USI = 4'd0;
    localparam logic [3:0] IRQ_SSI = 4'd1;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_UTI = 4'd4;
    localparam logic [3:0] IRQ_STI = 4'd5;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_UEI = 4'd8;
    localparam logic [3:0] IRQ_SEI = 4'd9;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam int EXC_PRIO_N = 14;
    localparam int IRQ_PRIO_N = 9;

    // Written highest priority first, so the highest-priority code sits in the top nibble
    localparam logic [4*EXC_PRIO_N-1:0] EXC_PRIO_LIST = {
        EXC_BREAKPOINT, EXC_INSN_PAGE, EXC_INSN_FAULT, EXC_ILLEGAL, EXC_INSN_MISALIGN,
        EXC_ECALL_U, EXC_ECALL_S, EXC_ECALL_M, EXC_STORE_MISALIGN, EXC_LOAD_MISALIGN,
        EXC_STORE_PAGE, EXC_LOAD_PAGE, EXC_STORE_FAULT, EXC_LOAD_FAULT
    };

    localparam logic [4*IRQ_PRIO_N-1:0] IRQ_PRIO_LIST = {
        IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI, IRQ_UEI, IRQ_USI, IRQ_UTI
    };

    typedef struct packed {
        logic       intr;
        logic [3:0] code;
    } mcause_t;

    function automatic logic [31:0] pack_mcause(input mcause_t c);
        return {c.intr, 27'b0, c.code};
    endfunction

endpackage

// File: rtl/priv_1_11_cause_prio.sv
// rtl/priv_1_11_cause_prio.sv - combinational trap cause selection, exceptions over interrupts
module priv_1_11_cause_prio
    import machine_mode_types_1_11_pkg::*;
#(
    parameter int EXC_W = 16
) (
    input  logic [EXC_W-1:0] exc_src,
    input  logic [11:0]      irq_pend,
    input  logic             mstatus_mie,
    output logic             valid,
    output logic             intr,
    output logic [3:0]       code
);

    logic       exc_hit;
    logic       irq_hit;
    logic [3:0] exc_code;
    logic [3:0] irq_code;
    logic       unused_bits;

    // Codes without a table entry (10, 14, reserved irq slots) never reach the scan
    assign unused_bits = ^{exc_src, irq_pend};

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        exc_hit  = 1'b0;
        exc_code = 4'd0;
        for (int i = 0; i < EXC_PRIO_N; i++) begin
            if (int'(EXC_PRIO_LIST[i*4 +: 4]) < EXC_W) begin
                if (exc_src[EXC_PRIO_LIST[i*4 +: 4]]) begin
                    exc_hit  = 1'b1;
                    exc_code = EXC_PRIO_LIST[i*4 +: 4];
                end
            end
        end
    end

    // Same scan for enabled pending interrupts
    always_comb begin
        irq_hit  = 1'b0;
        irq_code = 4'd0;
        for (int i = 0; i < IRQ_PRIO_N; i++) begin
            if (irq_pend[IRQ_PRIO_LIST[i*4 +: 4]]) begin
                irq_hit  = 1'b1;
                irq_code = IRQ_PRIO_LIST[i*4 +: 4];
            end
        end
    end

    assign valid = exc_hit | (irq_hit & mstatus_mie);
    assign intr  = ~exc_hit & irq_hit & mstatus_mie;
    assign code  = exc_hit ? exc_code : irq_code;

endmodule

// File: rtl/priv_1_11_trap_sequencer.sv
// rtl/priv_1_11_trap_sequencer.sv - machine-mode trap entry and mret sequencing toward CSR file and fetch
module priv_1_11_trap_sequencer
    import machine_mode_types_1_11_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int EXC_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [EXC_W-1:0]  exc_src,
    input  logic [11:0]       mip_in,
    input  logic [11:0]       mie_in,
    input  logic              mstatus_mie,
    input  logic              mstatus_mpie,
    input  logic [WORD_W-3:0] mtvec_base,
    input  logic [1:0]        mtvec_mode,
    input  logic [WORD_W-1:0] mepc_in,
    input  logic [WORD_W-1:0] epc,
    input  logic [WORD_W-1:0] mtval_in,
    input  logic              mret,
    input  logic              pipe_clear,
    output logic              stall_fetch,
    output logic              mepc_rup,
    output logic              mcause_rup,
    output logic              mtval_rup,
    output logic              mstatus_rup,
    output logic [WORD_W-1:0] mepc_next,
    output logic [WORD_W-1:0] mtval_next,
    output logic [WORD_W-1:0] mcause_next,
    output logic              mstatus_mie_next,
    output logic              mstatus_mpie_next,
    output logic              intr,
    output logic              insert_pc,
    output logic [WORD_W-1:0] priv_pc
);

    state_t            state;
    mcause_t           cause_q;
    logic [WORD_W-1:0] epc_q;
    logic [WORD_W-1:0] mtval_q;
    logic              p_valid;
    logic              p_intr;
    logic [3:0]        p_code;
    logic [WORD_W-1:0] trap_base;
    logic [WORD_W-1:0] trap_vec;
    logic              unused_lsbs;

    // Return addresses are word aligned, the low bits of the incoming PCs are dropped
    assign unused_lsbs = ^{epc[1:0], mepc_in[1:0]};

    priv_1_11_cause_prio #(
        .EXC_W(EXC_W)
    ) u_prio (
        .exc_src     (exc_src),
        .irq_pend    (mip_in & mie_in),
        .mstatus_mie (mstatus_mie),
        .valid       (p_valid),
        .intr        (p_intr),
        .code        (p_code)
    );

    assign trap_base = {mtvec_base, 2'b00};
    assign trap_vec  = trap_base + {{(WORD_W-6){1'b0}}, cause_q.code, 2'b00};

    // Sequencer state and the cause snapshot taken when a trap is accepted
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            mtval_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p_valid) begin
                        cause_q <= '{intr: p_intr, code: p_code};
                        epc_q   <= {epc[WORD_W-1:2], 2'b00};
                        mtval_q <= p_intr ? '0 : mtval_in;
                        state   <= ST_DRAIN;
                    end else if (mret) begin
                        state <= ST_RET;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_clear) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: state <= ST_REDIRECT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign mepc_next   = epc_q;
    assign mtval_next  = mtval_q;
    assign mcause_next = WORD_W'(pack_mcause(cause_q));
    assign intr        = cause_q.intr;

    // Strobes and redirect are pure state decodes, so each lasts exactly one state cycle
    always_comb begin
        stall_fetch       = 1'b0;
        mepc_rup          = 1'b0;
        mcause_rup        = 1'b0;
        mtval_rup         = 1'b0;
        mstatus_rup       = 1'b0;
        mstatus_mie_next  = 1'b0;
        mstatus_mpie_next = 1'b0;
        insert_pc         = 1'b0;
        priv_pc           = '0;
        case (state)
            ST_DRAIN: stall_fetch = 1'b1;
            ST_COMMIT: begin
                stall_fetch       = 1'b1;
                mepc_rup          = 1'b1;
                mcause_rup        = 1'b1;
                mtval_rup         = 1'b1;
                mstatus_rup       = 1'b1;
                mstatus_mpie_next = mstatus_mie;
                mstatus_mie_next  = 1'b0;
            end
            ST_REDIRECT: begin
                stall_fetch = 1'b1;
                insert_pc   = 1'b1;
                priv_pc     = (mtvec_mode == 2'd1 && cause_q.intr) ? trap_vec : trap_base;
            end
            ST_RET: begin
                mstatus_rup       = 1'b1;
                mstatus_mie_next  = mstatus_mpie;
                mstatus_mpie_next = 1'b1;
                insert_pc         = 1'b1;
                priv_pc           = {mepc_in[WORD_W-1:2], 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
// tb/tb_priv_1_11_trap_sequencer.sv - scoreboard bench for the M-mode trap sequencer
module tb_priv_1_11_trap_sequencer;

    logic        CLK;
    logic        RST;
    logic [15:0] exc_src;
    logic [11:0] mip_in;
    logic [11:0] mie_in;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [29:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [31:0] mepc_in;
    logic [31:0] epc;
    logic [31:0] mtval_in;
    logic        mret;
    logic        pipe_clear;
    logic        stall_fetch;
    logic        mepc_rup;
    logic        mcause_rup;
    logic        mtval_rup;
    logic        mstatus_rup;
    logic [31:0] mepc_next;
    logic [31:0] mtval_next;
    logic [31:0] mcause_next;
    logic        mstatus_mie_next;
    logic        mstatus_mpie_next;
    logic        intr;
    logic        insert_pc;
    logic [31:0] priv_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_ret;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] pc;
        logic        mie_n;
        logic        mpie_n;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    priv_1_11_trap_sequencer #(.WORD_W(32), .EXC_W(16)) dut (
        .CLK(CLK), .RST(RST), .exc_src(exc_src), .mip_in(mip_in), .mie_in(mie_in),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mtvec_base(mtvec_base),
        .mtvec_mode(mtvec_mode), .mepc_in(mepc_in), .epc(epc), .mtval_in(mtval_in),
        .mret(mret), .pipe_clear(pipe_clear), .stall_fetch(stall_fetch), .mepc_rup(mepc_rup),
        .mcause_rup(mcause_rup), .mtval_rup(mtval_rup), .mstatus_rup(mstatus_rup),
        .mepc_next(mepc_next), .mtval_next(mtval_next), .mcause_next(mcause_next),
        .mstatus_mie_next(mstatus_mie_next), .mstatus_mpie_next(mstatus_mpie_next),
        .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b1; exc_src = 16'hFFFF; mip_in = 12'hFFF; mie_in = 12'hFFF;
        mstatus_mie = 1'b1; mstatus_mpie = 1'b0; mtvec_base = 30'h400; mtvec_mode = 2'd0;
        mepc_in = 32'h0; epc = 32'h0; mtval_in = 32'h0; mret = 1'b1; pipe_clear = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge CLK);
            checks++;
            if ({stall_fetch, mepc_rup, mcause_rup, mtval_rup, mstatus_rup, insert_pc, intr,
                 mstatus_mie_next, mstatus_mpie_next} !== 9'b0) begin
                errors++; $display("FAIL reset_ctrl cycle %0d got %b want 0", cyc,
                    {stall_fetch, mepc_rup, mcause_rup, mtval_rup, mstatus_rup, insert_pc, intr,
                     mstatus_mie_next, mstatus_mpie_next});
            end
            checks++;
            if ((mepc_next | mtval_next | mcause_next | priv_pc) !== 32'h0) begin
                errors++; $display("FAIL reset_data cycle %0d mepc %h mtval %h mcause %h pc %h want 0",
                    cyc, mepc_next, mtval_next, mcause_next, priv_pc);
            end
        end
        exc_src = 16'h0; mip_in = 12'h0; mie_in = 12'h0; mret = 1'b0; RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({stall_fetch, insert_pc, mstatus_rup} !== 3'b0) begin
            errors++; $display("FAIL reset_release got %b want 000", {stall_fetch, insert_pc, mstatus_rup});
        end
    endtask

    task automatic test_priority();
        exp_t e;
        int   n_ins = 0;
        e = '{1'b0, 32'h3, 32'h100, 32'hDEADBEEF, 32'h1000, 1'b0, 1'b1, 3};
        exp_q.push_back(e);
        epc = 32'h100; mtval_in = 32'hDEADBEEF; pipe_clear = 1'b1; exc_src = 16'h000C;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK);
            if (cyc <= 3) begin
                checks++;
                if (stall_fetch !== 1'b1) begin errors++; $display("FAIL prio_stall cycle %0d got %b want 1", cyc, stall_fetch); end
            end
            if (mcause_rup) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL prio_commit unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q[0];
                    checks++;
                    if ({mepc_rup, mtval_rup, mstatus_rup} !== 3'b111) begin errors++; $display("FAIL prio_strobes got %b want 111", {mepc_rup, mtval_rup, mstatus_rup}); end
                    checks++;
                    if (mcause_next !== e.mcause) begin errors++; $display("FAIL prio_mcause got %h want %h", mcause_next, e.mcause); end
                    checks++;
                    if (mepc_next !== e.mepc) begin errors++; $display("FAIL prio_mepc got %h want %h", mepc_next, e.mepc); end
                    checks++;
                    if (mtval_next !== e.mtval) begin errors++; $display("FAIL prio_mtval got %h want %h", mtval_next, e.mtval); end
                    checks++;
                    if ({mstatus_mie_next, mstatus_mpie_next} !== {e.mie_n, e.mpie_n}) begin errors++; $display("FAIL prio_mstatus got %b want %b", {mstatus_mie_next, mstatus_mpie_next}, {e.mie_n, e.mpie_n}); end
                end
            end
            if (insert_pc) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL prio_insert unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    n_ins++;
                    checks++;
                    if (priv_pc !== e.pc) begin errors++; $display("FAIL prio_pc got %h want %h", priv_pc, e.pc); end
                    checks++;
                    if (cyc != e.lat) begin errors++; $display("FAIL prio_latency got %0d want %0d", cyc, e.lat); end
                    checks++;
                    if (intr !== e.mcause[31]) begin errors++; $display("FAIL prio_intr got %b want %b", intr, e.mcause[31]); end
                end
            end
            if (cyc == 1) exc_src = 16'h0;
        end
        checks++;
        if (n_ins != 1) begin errors++; $display("FAIL prio_insert_count got %0d want 1", n_ins); end
        exp_q.delete();
    endtask

    task automatic test_vectored_irq();
        exp_t e;
        int   n_ins = 0;
        e = '{1'b0, 32'h8000000B, 32'h204, 32'h0, 32'h42C, 1'b0, 1'b1, 3};
        exp_q.push_back(e);
        mtvec_base = 30'h100; mtvec_mode = 2'd1; epc = 32'h206; mtval_in = 32'h1234;
        mip_in = 12'h880; mie_in = 12'h880; mstatus_mie = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK);
            if (mcause_rup) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL virq_commit unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q[0];
                    checks++;
                    if (mcause_next !== e.mcause) begin errors++; $display("FAIL virq_mcause got %h want %h", mcause_next, e.mcause); end
                    checks++;
                    if (mepc_next !== e.mepc) begin errors++; $display("FAIL virq_mepc got %h want %h", mepc_next, e.mepc); end
                    checks++;
                    if (mtval_next !== e.mtval) begin errors++; $display("FAIL virq_mtval got %h want %h", mtval_next, e.mtval); end
                    checks++;
                    if ({mstatus_mie_next, mstatus_mpie_next} !== {e.mie_n, e.mpie_n}) begin errors++; $display("FAIL virq_mstatus got %b want %b", {mstatus_mie_next, mstatus_mpie_next}, {e.mie_n, e.mpie_n}); end
                end
            end
            if (insert_pc) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL virq_insert unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    n_ins++;
                    checks++;
                    if (priv_pc !== e.pc) begin errors++; $display("FAIL virq_pc got %h want %h", priv_pc, e.pc); end
                    checks++;
                    if (cyc != e.lat) begin errors++; $display("FAIL virq_latency got %0d want %0d", cyc, e.lat); end
                    checks++;
                    if (intr !== e.mcause[31]) begin errors++; $display("FAIL virq_intr got %b want %b", intr, e.mcause[31]); end
                end
            end
            if (cyc == 1) begin mip_in = 12'h0; mie_in = 12'h0; end
        end
        checks++;
        if (n_ins != 1) begin errors++; $display("FAIL virq_insert_count got %0d want 1", n_ins); end
        exp_q.delete();
        mtvec_base = 30'h400; mtvec_mode = 2'd0;
    endtask

    task automatic test_drain_hold();
        exp_t e;
        int   commit_cyc = -1;
        int   n_ins = 0;
        e = '{1'b0, 32'h2, 32'h300, 32'h55, 32'h1000, 1'b0, 1'b1, 7};
        exp_q.push_back(e);
        epc = 32'h300; mtval_in = 32'h55; pipe_clear = 1'b0; exc_src = 16'h0004;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (cyc <= 7) begin
                checks++;
                if (stall_fetch !== 1'b1) begin errors++; $display("FAIL drain_stall cycle %0d got %b want 1", cyc, stall_fetch); end
            end
            if (mcause_rup) begin
                commit_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL drain_commit unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q[0];
                    checks++;
                    if (mcause_next !== e.mcause) begin errors++; $display("FAIL drain_mcause got %h want %h", mcause_next, e.mcause); end
                    checks++;
                    if (mepc_next !== e.mepc) begin errors++; $display("FAIL drain_mepc got %h want %h", mepc_next, e.mepc); end
                    checks++;
                    if (mtval_next !== e.mtval) begin errors++; $display("FAIL drain_mtval got %h want %h", mtval_next, e.mtval); end
                end
            end
            if (insert_pc) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL drain_insert unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    n_ins++;
                    checks++;
                    if (priv_pc !== e.pc) begin errors++; $display("FAIL drain_pc got %h want %h", priv_pc, e.pc); end
                    checks++;
                    if (cyc != e.lat) begin errors++; $display("FAIL drain_latency got %0d want %0d", cyc, e.lat); end
                end
            end
            case (cyc)
                1: exc_src = 16'h0;
                3: exc_src = 16'h0008;
                5: begin exc_src = 16'h0; pipe_clear = 1'b1; end
                default: ;
            endcase
        end
        checks++;
        if (commit_cyc != 6) begin errors++; $display("FAIL drain_commit_cycle got %0d want 6", commit_cyc); end
        checks++;
        if (n_ins != 1) begin errors++; $display("FAIL drain_insert_count got %0d want 1", n_ins); end
        exp_q.delete();
    endtask

    task automatic test_mret();
        exp_t e;
        e = '{1'b1, 32'h0, 32'h0, 32'h0, 32'h2000, 1'b1, 1'b1, 1};
        exp_q.push_back(e);
        mepc_in = 32'h2003; mstatus_mpie = 1'b1; mstatus_mie = 1'b0; mret = 1'b1;
        @(negedge CLK);
        mret = 1'b0;
        checks++;
        if ({mstatus_rup, mepc_rup, mcause_rup, mtval_rup} !== 4'b1000) begin errors++; $display("FAIL mret_strobes got %b want 1000", {mstatus_rup, mepc_rup, mcause_rup, mtval_rup}); end
        checks++;
        if ({mstatus_mie_next, mstatus_mpie_next} !== {exp_q[0].mie_n, exp_q[0].mpie_n}) begin errors++; $display("FAIL mret_mstatus got %b want 11", {mstatus_mie_next, mstatus_mpie_next}); end
        checks++;
        if (insert_pc !== 1'b1) begin errors++; $display("FAIL mret_insert got %b want 1", insert_pc); end
        else begin
            e = exp_q.pop_front();
            checks++;
            if (priv_pc !== e.pc) begin errors++; $display("FAIL mret_pc got %h want %h", priv_pc, e.pc); end
        end
        @(negedge CLK);
        checks++;
        if ({mstatus_rup, insert_pc} !== 2'b00) begin errors++; $display("FAIL mret_one_cycle got %b want 00", {mstatus_rup, insert_pc}); end
        exp_q.delete();
        mstatus_mie = 1'b1; mstatus_mpie = 1'b0;
    endtask

    task automatic test_collision();
        exp_t e;
        int   n_ins = 0;
        e = '{1'b0, 32'hB, 32'h500, 32'h77, 32'h1000, 1'b0, 1'b1, 3};
        exp_q.push_back(e);
        epc = 32'h500; mtval_in = 32'h77; pipe_clear = 1'b1; mret = 1'b1; exc_src = 16'h0800;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                checks++;
                if ({mstatus_rup, insert_pc} !== 2'b00) begin errors++; $display("FAIL coll_no_ret got %b want 00", {mstatus_rup, insert_pc}); end
            end
            if (mcause_rup) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL coll_commit unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q[0];
                    checks++;
                    if (mcause_next !== e.mcause) begin errors++; $display("FAIL coll_mcause got %h want %h", mcause_next, e.mcause); end
                    checks++;
                    if (mepc_next !== e.mepc) begin errors++; $display("FAIL coll_mepc got %h want %h", mepc_next, e.mepc); end
                end
            end
            if (insert_pc) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL coll_insert unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    n_ins++;
                    checks++;
                    if (priv_pc !== e.pc) begin errors++; $display("FAIL coll_pc got %h want %h", priv_pc, e.pc); end
                    checks++;
                    if (cyc != e.lat) begin errors++; $display("FAIL coll_latency got %0d want %0d", cyc, e.lat); end
                end
            end
            if (cyc == 1) begin mret = 1'b0; exc_src = 16'h0; end
        end
        checks++;
        if (n_ins != 1) begin errors++; $display("FAIL coll_insert_count got %0d want 1", n_ins); end
        exp_q.delete();
    endtask

    task automatic test_reset_in_drain();
        epc = 32'h900; pipe_clear = 1'b0; exc_src = 16'h0001;
        @(negedge CLK);
        checks++;
        if (stall_fetch !== 1'b1) begin errors++; $display("FAIL rstdrain_in_drain got %b want 1", stall_fetch); end
        RST = 1'b1; exc_src = 16'h0;
        @(negedge CLK);
        RST = 1'b0; pipe_clear = 1'b1;
        for (int cyc = 2; cyc <= 7; cyc++) begin
            checks++;
            if ({stall_fetch, mepc_rup, mcause_rup, mtval_rup, mstatus_rup, insert_pc} !== 6'b0) begin
                errors++; $display("FAIL rstdrain_quiet cycle %0d got %b want 0", cyc,
                    {stall_fetch, mepc_rup, mcause_rup, mtval_rup, mstatus_rup, insert_pc});
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n_ins = 0;
        logic prev_ins = 1'b0;
        logic prev_rup = 1'b0;
        e = '{1'b0, 32'h2, 32'h600, 32'h11, 32'h1000, 1'b0, 1'b1, 3};
        exp_q.push_back(e);
        e = '{1'b0, 32'h1, 32'h700, 32'h22, 32'h1000, 1'b0, 1'b1, 7};
        exp_q.push_back(e);
        epc = 32'h600; mtval_in = 32'h11; pipe_clear = 1'b1; exc_src = 16'h0004;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            checks++;
            if ((prev_ins && insert_pc) || (prev_rup && mcause_rup)) begin
                errors++; $display("FAIL b2b_pulse_width cycle %0d insert %b rup %b held over", cyc, insert_pc, mcause_rup);
            end
            prev_ins = insert_pc;
            prev_rup = mcause_rup;
            if (mcause_rup) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_commit unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q[0];
                    checks++;
                    if (mcause_next !== e.mcause) begin errors++; $display("FAIL b2b_mcause got %h want %h", mcause_next, e.mcause); end
                    checks++;
                    if (mepc_next !== e.mepc) begin errors++; $display("FAIL b2b_mepc got %h want %h", mepc_next, e.mepc); end
                    checks++;
                    if (mtval_next !== e.mtval) begin errors++; $display("FAIL b2b_mtval got %h want %h", mtval_next, e.mtval); end
                end
            end
            if (insert_pc) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_insert unexpected at cycle %0d", cyc); end
                else begin
                    e = exp_q.pop_front();
                    n_ins++;
                    checks++;
                    if (priv_pc !== e.pc) begin errors++; $display("FAIL b2b_pc got %h want %h", priv_pc, e.pc); end
                    checks++;
                    if (cyc != e.lat) begin errors++; $display("FAIL b2b_latency got %0d want %0d", cyc, e.lat); end
                end
            end
            case (cyc)
                4: begin exc_src = 16'h0002; epc = 32'h703; mtval_in = 32'h22; end
                5: exc_src = 16'h0;
                default: ;
            endcase
        end
        checks++;
        if (n_ins != 2) begin errors++; $display("FAIL b2b_insert_count got %0d want 2", n_ins); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_vectored_irq();
        test_drain_hold();
        test_mret();
        test_collision();
        test_reset_in_drain();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priv_1_11_trap_sequencer.md
Name: priv_1_11_trap_sequencer

Overview:
- Sequences machine-mode trap entry and mret return for the 1.11 privilege block.
- Latches exception/interrupt sources and picks the highest-priority cause per spec 1.11.
- Stalls fetch and waits for a clear pipeline, then issues the single-cycle CSR update strobes (mepc/mcause/mtval/mstatus). Finally drives the PC redirect to the pipeline controller.
- Sits between hazard/pipeline logic and the CSR file; the CSR file consumes its *_rup/*_next outputs.

Parameters:
- WORD_W, 32, data/PC width
- EXC_W, 16, width of exception source vector (bit index = mcause exception code)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- exc_src  in  EXC_W  exception requests, bit n = code n; sampled in IDLE only
- mip_in  in  12  pending interrupts, mip layout
- mie_in  in  12  interrupt enables, mie layout
- mstatus_mie  in  1  global M interrupt enable
- mstatus_mpie  in  1  current MPIE
- mtvec_base  in  WORD_W-2  mtvec.BASE
- mtvec_mode  in  2  0=direct, 1=vectored, others treated as direct
- mepc_in  in  WORD_W  current mepc
- epc  in  WORD_W  PC of faulting/interrupted instruction
- mtval_in  in  WORD_W  faulting address/instruction
- mret  in  1  mret in commit stage
- pipe_clear  in  1  pipeline drained
- stall_fetch  out  1  hold fetch during trap/return sequencing
- mepc_rup, mcause_rup, mtval_rup, mstatus_rup  out  1 each  one-cycle CSR write strobes
- mepc_next, mtval_next  out  WORD_W  CSR write data
- mcause_next  out  WORD_W  {intr, 27'b0, code[3:0]}
- mstatus_mie_next, mstatus_mpie_next  out  1 each
- intr  out  1  latched cause is an interrupt
- insert_pc  out  1  redirect request, one cycle
- priv_pc  out  WORD_W  redirect target

Behaviour:
- Reset: state=IDLE; all outputs 0; latched cause/epc/mtval cleared. Reset mid-sequence aborts with no strobes on the following cycle.
- irq_any = |(mip_in & mie_in) & mstatus_mie. exc_any = |exc_src.
- Exception priority, high to low: 3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5. Codes outside this list are ignored.
- Interrupt priority, high to low: 11, 3, 7, 9, 1, 5, 8, 0, 4.
- Exceptions always beat interrupts in the same cycle.
- States: IDLE, DRAIN, COMMIT, REDIRECT, RET.
- IDLE:
  - On exc_any or irq_any: latch code, intr, epc, and mtval (mtval forced to 0 for interrupts); go to DRAIN.
  - Else if mret: go to RET.
  - Trap beats a simultaneous mret.
- DRAIN: stall_fetch=1. Cause is frozen; later source changes are ignored. Stay until pipe_clear=1, then go to COMMIT.
- COMMIT: stall_fetch=1, for exactly 1 cycle.
  - mepc_rup=mcause_rup=mtval_rup=mstatus_rup=1.
  - mepc_next = latched epc with bits[1:0] cleared.
  - mstatus_mpie_next = mstatus_mie; mstatus_mie_next = 0.
  - Go to REDIRECT.
- REDIRECT: insert_pc=1 for 1 cycle, stall_fetch=1, intr held. Then IDLE.
  - priv_pc = {mtvec_base,2'b00} by default.
  - Vectored mode with intr=1: priv_pc = {mtvec_base,2'b00} + 4*code, 32-bit wrap.
- RET: 1 cycle.
  - mstatus_rup=1; mstatus_mie_next = mstatus_mpie; mstatus_mpie_next = 1.
  - insert_pc=1, priv_pc = mepc_in with bits[1:0] cleared. Then IDLE.
- Latency from trap detect to insert_pc: 2 cycles plus DRAIN wait. With pipe_clear already high, insert_pc appears 3 cycles after detection.
- Back-to-back: a new source pending in the first IDLE cycle after REDIRECT is accepted normally. The mstatus_mie just cleared masks interrupts.
- All *_rup and insert_pc are never high for more than 1 consecutive cycle.

Decomposition:
- Shared package machine_mode_types_1_11_pkg holds:
  - the state enum
  - exception/interrupt code constants
  - the priority order lists
  - the mcause_t pack helper
- One sub-module: priv_1_11_cause_prio. It is combinational and computes {valid, intr, code[3:0]} from exc_src, mip&mie, and mstatus_mie.

Test Plan:
1. Reset: hold RST 3 cycles with exc_src=16'hFFFF → all outputs 0, state IDLE.
2. Priority: exc_src has bits 2 and 3 set, epc=0x100, pipe_clear=1 → mcause_next=0x3, mepc_next=0x100, insert_pc at cycle 3, priv_pc=mtvec.
3. Vectored interrupt: mip=mie=12'h880, mstatus_mie=1, mtvec_base=0x400>>2, mode=1 → mcause_next=0x8000000B, mtval_next=0, priv_pc=0x42C.
4. Drain hold: exception 0x2, pipe_clear held low 5 cycles, exc_src dropped after 1 cycle → stall_fetch high throughout, COMMIT only after pipe_clear rises, cause still 0x2.
5. mret: mepc_in=0x2003, mstatus_mpie=1, mret=1 → 1-cycle mstatus_rup with mie_next=1, mpie_next=1; insert_pc with priv_pc=0x2000.
6. Collisions:
   - mret and exception 0xB in the same cycle → trap taken, no RET strobe.
   - RST asserted during DRAIN → no strobes afterward.
